multicycle_ctrl: RTL
====================

# multicycle_ctrl

Multi-cycle sequencer for the processor datapath. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the per-cycle datapath controls: register-file, ALU, PC, IR and shared-memory strobes. It arbitrates one single-port memory between instruction fetch and data access through a req/ack handshake with a timeout watchdog. It sits between the instruction register's opcode field and the datapath, and supersedes pure combinational opcode decoding.

## Interface
- `TIMEOUT`, 16: max cycles `mem_req` may stay high without `mem_ack` before bus error.
- `CNT_W`, 16: width of retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  8  opcode field of IR; sampled in DECODE only.
- `mem_ack`  in  1  memory completes transfer this cycle; ignored outside FETCH/MEM.
- `zero`  in  1  ALU zero flag; sampled in EXEC of BEQ.
- `mem_req`, `mem_we`, `i_or_d`  out  1 each  memory request, write, address select (0=PC, 1=ALU result).
- `ir_write`, `pc_write`, `pc_src`  out  1 each  IR load, PC update, PC source (0=PC+1, 1=branch target).
- `reg_write`, `reg_dst`, `mem_to_reg`, `alu_src`, `branch`  out  1 each  datapath controls.
- `alu_op`  out  8  ALU operation.
- `illegal`  out  1  one-cycle pulse on undefined opcode.
- `bus_err`, `halted`  out  1 each  sticky until reset.
- `retired`  out  CNT_W  instructions completed; wraps.

## Operation
- Opcodes: 8'h01 ALU (R-type), 8'h02 NOP, 8'h03 LOAD, 8'h04 STORE, 8'h05 BEQ, 8'hFF HALT. All others are illegal.
- States: RESET, FETCH, DECODE, EXEC, MEM, WB, HALT. `rst_n` low forces RESET. RESET always advances to FETCH the next cycle.
- FETCH: `mem_req`=1, `i_or_d`=0. Stay until `mem_ack`=1. In the ack cycle `ir_write`=`pc_write`=1 and `pc_src`=0. Next state is DECODE.
- DECODE: latch `opcode` into `op_q`.
  - ALU/LOAD/STORE/BEQ go to EXEC.
  - NOP goes to FETCH and counts as retired.
  - HALT goes to HALT and counts as retired.
  - Illegal: `illegal`=1 this cycle, go to FETCH, not retired.
- EXEC:
  - ALU: `alu_op`=`op_q`, `alu_src`=0, next state WB.
  - LOAD/STORE: `alu_op`=8'h10 (ADD), `alu_src`=1, next state MEM.
  - BEQ: `alu_op`=8'h11 (SUB), `branch`=1, `pc_src`=1, `pc_write`=`zero`, next state FETCH, retired.
- MEM: `mem_req`=1, `i_or_d`=1, `mem_we`=1 for STORE. Stay until `mem_ack`. On ack, LOAD goes to WB; STORE goes to FETCH and is retired.
- WB: `reg_write`=1. ALU: `reg_dst`=1, `mem_to_reg`=0. LOAD: `reg_dst`=0, `mem_to_reg`=1. Next state FETCH, retired.
- HALT: `halted`=1. The state is absorbing until `rst_n` is asserted. No memory requests are issued.
- Watchdog: counts consecutive cycles with `mem_req`=1 and `mem_ack`=0. When the count reaches `TIMEOUT`, set `bus_err` and go to HALT; `mem_req` drops the next cycle. The count clears on ack or on leaving FETCH/MEM.
- Every output not named for the current state/opcode is 0, including `alu_op`=8'h00.

## Timing
- All outputs are combinational decodes of the registered state, `op_q`, `mem_ack` and `zero`. `illegal` is also decoded from `opcode` in DECODE. No output depends on any other input.
- Reset value of all outputs is 0 while `rst_n` is low and in RESET; `retired` is 0.
- Zero-wait memory latency per instruction type:
  - NOP/HALT: 2 cycles.
  - BEQ: 3 cycles.
  - ALU and STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each wait cycle adds 1.
- `mem_req` stays asserted, with `i_or_d`/`mem_we` stable, until the ack cycle. It deasserts the cycle after ack.
- `retired` increments on the clock edge leaving the completing state. It wraps from 2^CNT_W-1 to 0.
- Async reset mid-transaction aborts immediately. `mem_req` drops asynchronously and there is no replay.
- A `mem_ack` in the same cycle the watchdog reaches `TIMEOUT` wins: the transfer completes and there is no `bus_err`.

## Structure
- Package `ctrl_pkg` holds:
  - the state enum;
  - opcode constants `OP_ALU`, `OP_NOP`, `OP_LOAD`, `OP_STORE`, `OP_BEQ`, `OP_HALT`;
  - ALU op constants `ALU_ADD`=8'h10 and `ALU_SUB`=8'h11.
- Sub-module `ack_timer`: parameterised watchdog counter with inputs `req`/`ack` and output `expired`.

## Test plan
- Reset, then opcode 8'h01 with `mem_ack` high every cycle: states FETCH, DECODE, EXEC, WB. In EXEC `alu_op`=8'h01. In WB `reg_write`=`reg_dst`=1. `retired`=1 after 4 cycles.
- LOAD with fetch ack delayed 3 cycles and data ack delayed 2 cycles:
  - `mem_req` is held in each wait.
  - `i_or_d`=0 in FETCH and 1 in MEM.
  - In WB `mem_to_reg`=1.
  - Total 10 cycles.
- BEQ: with `zero`=1 then `pc_write`=`pc_src`=1 in EXEC. With `zero`=0 then `pc_write`=0. Both cases are retired.
- Opcode 8'h7E: `illegal` pulses exactly 1 cycle and `retired` is unchanged. Then opcode 8'hFF: `halted`=1 and `mem_req` stays 0 for 20 cycles.
- `TIMEOUT`=4 with `mem_ack` never asserted in FETCH: `bus_err`=`halted`=1 after 4 request cycles. Ack on exactly the 4th cycle gives no `bus_err`.
- Assert `rst_n` low mid-MEM of a STORE: all outputs are 0 asynchronously, `retired`=0, and the block restarts at FETCH after RESET. Run 2^16 NOPs: `retired` wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    localparam logic [7:0] OP_ALU   = 8'h01;
    localparam logic [7:0] OP_NOP   = 8'h02;
    localparam logic [7:0] OP_LOAD  = 8'h03;
    localparam logic [7:0] OP_STORE = 8'h04;
    localparam logic [7:0] OP_BEQ   = 8'h05;
    localparam logic [7:0] OP_HALT  = 8'hFF;

    localparam logic [7:0] ALU_ADD  = 8'h10;
    localparam logic [7:0] ALU_SUB  = 8'h11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Shared single-port memory handshake between the sequencer and the memory.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ack;

    modport master (output mem_req, output mem_we, output i_or_d, input mem_ack);
    modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ack);
endinterface

// File: rtl/multicycle_ctrl_ack_timer.sv
// Watchdog: counts consecutive requested-but-unacknowledged cycles.
module ack_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Any cycle without an outstanding unacked request restarts the count.
    always_comb begin
        count_d = '0;
        if (req && !ack) begin
            count_d = count_q + 1'b1;
        end
    end

    // Fires in the cycle that would make the count reach TIMEOUT; an ack then wins.
    assign expired = req && !ack && (count_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle instruction sequencer driving datapath strobes and the shared memory port.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_ctrl_if.master      mem,
    input  logic [7:0]             opcode,
    input  logic                   zero,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_src,
    output logic                   reg_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   alu_src,
    output logic                   branch,
    output logic [7:0]             alu_op,
    output logic                   illegal,
    output logic                   bus_err,
    output logic                   halted,
    output logic [CNT_W-1:0]       retired
);

    state_e             state_q, state_d;
    logic [7:0]         op_q, op_d;
    logic [CNT_W-1:0]   retired_q;
    logic               bus_err_q;
    logic               retire;
    logic               bus_err_set;
    logic               req, we, iod;
    logic               expired;

    ack_timer #(.TIMEOUT(TIMEOUT)) u_ack_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .ack     (mem.mem_ack),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        retire      = 1'b0;
        bus_err_set = 1'b0;
        req         = 1'b0;
        we          = 1'b0;
        iod         = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src     = 1'b0;
        branch      = 1'b0;
        alu_op      = 8'h00;
        illegal     = 1'b0;
        halted      = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                req = 1'b1;
                if (mem.mem_ack) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end else if (expired) begin
                    bus_err_set = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_ALU, OP_LOAD, OP_STORE, OP_BEQ: state_d = ST_EXEC;
                    OP_NOP: begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = ST_FETCH;
                    end
                endcase
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ALU: begin
                        alu_op  = op_q;
                        state_d = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_op  = ALU_ADD;
                        alu_src = 1'b1;
                        state_d = ST_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        branch   = 1'b1;
                        pc_src   = 1'b1;
                        pc_write = zero;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                req = 1'b1;
                iod = 1'b1;
                we  = (op_q == OP_STORE);
                if (mem.mem_ack) begin
                    if (op_q == OP_LOAD) begin
                        state_d = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                end else if (expired) begin
                    bus_err_set = 1'b1;
                    state_d     = ST_HALT;
                end
            end
            ST_WB: begin
                reg_write  = 1'b1;
                reg_dst    = (op_q == OP_ALU);
                mem_to_reg = (op_q == OP_LOAD);
                retire     = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            op_q      <= 8'h00;
            retired_q <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            if (retire) begin
                retired_q <= retired_q + 1'b1;
            end
            if (bus_err_set) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign mem.mem_req = req;
    assign mem.mem_we  = we;
    assign mem.i_or_d  = iod;
    assign bus_err     = bus_err_q;
    assign retired     = retired_q;

endmodule
